// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter: round-robin share of one bitwise logic unit (NOT/AND/OR/XOR)
//   between NUM_REQ valid/ready requesters, with a single registered result slot.
// Latency: accept in cycle N -> rsp_valid with result in cycle N+1; 1 op/cycle max.
// Backpressure: when the slot is full and rsp_ready=0, no requester is ready and
//   rsp_id/rsp_data hold.
//
// Ports:
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   req_valid/req_ready  per-requester handshake (req_ready is one-hot or zero)
//   req_op               2 bits per requester: 00 ~a, 01 a&b, 10 a|b, 11 a^b
//   req_a, req_b         DATA_W bits per requester (b unused for NOT)
//   rsp_valid/rsp_ready  result handshake
//   rsp_id, rsp_data     requester index and result held in the slot
//
// NUM_REQ must be at least 2. ID_W is derived and must not be overridden.

module logic_unit_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*2-1:0]      req_op,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_data
);

  // One extra bit so rr_ptr + offset never overflows before the modulo fold.
  localparam int CW = ID_W + 1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;

  logic [1:0]          op_arr [NUM_REQ];
  logic [DATA_W-1:0]   a_arr  [NUM_REQ];
  logic [DATA_W-1:0]   b_arr  [NUM_REQ];

  logic [CW-1:0]       cand;
  logic                win_found;
  logic [ID_W-1:0]     win_idx;
  logic                slot_free;
  logic                accept;
  logic [DATA_W-1:0]   result;

  // Unpack the flat requester buses into per-requester arrays.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      op_arr[i] = req_op[2*i +: 2];
      a_arr[i]  = req_a[DATA_W*i +: DATA_W];
      b_arr[i]  = req_b[DATA_W*i +: DATA_W];
    end
  end

  // Round-robin search: first valid requester starting at rr_ptr, wrapping
  // modulo NUM_REQ. The fold keeps non-power-of-2 NUM_REQ in range.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + CW'(k);
      if (cand >= CW'(NUM_REQ)) begin
        cand = cand - CW'(NUM_REQ);
      end
      if (!win_found && req_valid[cand[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[ID_W-1:0];
      end
    end
  end

  // The slot can take a new result if it is empty or is being drained now.
  assign slot_free = (state_q == EMPTY) | rsp_ready;

  // Only the winner ever sees ready, and nobody does while reset is held.
  always_comb begin
    req_ready = '0;
    if (win_found && slot_free && !rst) begin
      req_ready[win_idx] = 1'b1;
    end
  end

  assign accept = req_valid[win_idx] & req_ready[win_idx];

  // The shared logic unit, fed by the winning requester's operands.
  always_comb begin
    result = '0;
    unique case (op_arr[win_idx])
      2'b00:   result = ~a_arr[win_idx];
      2'b01:   result = a_arr[win_idx] & b_arr[win_idx];
      2'b10:   result = a_arr[win_idx] | b_arr[win_idx];
      default: result = a_arr[win_idx] ^ b_arr[win_idx];
    endcase
  end

  // Slot FSM and round-robin pointer next-state.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    rsp_id_d   = rsp_id_q;
    rsp_data_d = rsp_data_q;
    if (accept) begin
      // EMPTY -> FULL, or FULL reloaded in the same cycle it drains.
      state_d    = FULL;
      rsp_id_d   = win_idx;
      rsp_data_d = result;
      if (win_idx == ID_W'(NUM_REQ - 1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = win_idx + ID_W'(1);
      end
    end else if (state_q == FULL && rsp_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      rr_ptr_q   <= '0;
      rsp_id_q   <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      rsp_id_q   <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign rsp_valid = (state_q == FULL);
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// tb_logic_unit_arbiter: drives a 4-requester and a 3-requester arbiter side by side,
//   compares every cycle against a queue-free slot/pointer model, plus literal pins.
// Outputs sampled on the falling edge; inputs change 1 time unit after the rising edge.

module tb_logic_unit_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [3:0]  rv   [2];
  logic [1:0]  opv  [2][4];
  logic [7:0]  av   [2][4];
  logic [7:0]  bv   [2][4];
  logic        rspr [2];

  logic [7:0]  op4;
  logic [31:0] a4, b4;
  logic [5:0]  op3;
  logic [23:0] a3, b3;

  logic [3:0]  rdy4;
  logic [2:0]  rdy3;
  logic        vld4, vld3;
  logic [1:0]  id4, id3;
  logic [7:0]  dat4, dat3;

  int vectors    = 0;
  int miscompares = 0;
  logic chk_en = 1'b0;

  // Model state per DUT.
  logic       m_valid [2];
  int         m_id    [2];
  logic [7:0] m_data  [2];
  int         m_ptr   [2];
  logic [3:0] exp_rdy [2];

  always #5 clk = ~clk;

  always_comb begin
    op4 = '0; a4 = '0; b4 = '0; op3 = '0; a3 = '0; b3 = '0;
    for (int i = 0; i < 4; i++) begin
      op4[2*i +: 2] = opv[0][i];
      a4[8*i +: 8]  = av[0][i];
      b4[8*i +: 8]  = bv[0][i];
    end
    for (int i = 0; i < 3; i++) begin
      op3[2*i +: 2] = opv[1][i];
      a3[8*i +: 8]  = av[1][i];
      b3[8*i +: 8]  = bv[1][i];
    end
  end

  logic_unit_arbiter #(.NUM_REQ(4), .DATA_W(8)) dut4 (
    .clk(clk), .rst(rst), .req_valid(rv[0]), .req_ready(rdy4),
    .req_op(op4), .req_a(a4), .req_b(b4),
    .rsp_valid(vld4), .rsp_ready(rspr[0]), .rsp_id(id4), .rsp_data(dat4)
  );

  logic_unit_arbiter #(.NUM_REQ(3), .DATA_W(8)) dut3 (
    .clk(clk), .rst(rst), .req_valid(rv[1][2:0]), .req_ready(rdy3),
    .req_op(op3), .req_a(a3), .req_b(b3),
    .rsp_valid(vld3), .rsp_ready(rspr[1]), .rsp_id(id3), .rsp_data(dat3)
  );

  function automatic int nreq(int d);
    return (d == 0) ? 4 : 3;
  endfunction

  function automatic logic [7:0] lop(logic [1:0] op, logic [7:0] a, logic [7:0] b);
    case (op)
      2'd0:    return ~a;
      2'd1:    return a & b;
      2'd2:    return a | b;
      default: return a ^ b;
    endcase
  endfunction

  // First valid requester scanning ptr, ptr+1, ... modulo n; -1 if none.
  function automatic int win_of(int d);
    for (int k = 0; k < nreq(d); k++) begin
      if (rv[d][(m_ptr[d] + k) % nreq(d)]) return (m_ptr[d] + k) % nreq(d);
    end
    return -1;
  endfunction

  function automatic logic slot_free(int d);
    return !m_valid[d] || rspr[d];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        m_valid[d] <= 1'b0;
        m_id[d]    <= 0;
        m_data[d]  <= 8'h00;
        m_ptr[d]   <= 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (win_of(d) >= 0 && slot_free(d)) begin
          m_valid[d] <= 1'b1;
          m_id[d]    <= win_of(d);
          m_data[d]  <= lop(opv[d][win_of(d)], av[d][win_of(d)], bv[d][win_of(d)]);
          m_ptr[d]   <= (win_of(d) + 1) % nreq(d);
        end else if (m_valid[d] && rspr[d]) begin
          m_valid[d] <= 1'b0;
        end
      end
    end
  end

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, got, exp);
    end
  endtask

  logic [3:0] g_rdy;
  logic       g_vld;
  logic [1:0] g_id;
  logic [7:0] g_dat;

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        exp_rdy[d] = 4'b0000;
        if (!rst && win_of(d) >= 0 && slot_free(d)) exp_rdy[d] = 4'b0001 << win_of(d);
        g_rdy = (d == 0) ? rdy4 : {1'b0, rdy3};
        g_vld = (d == 0) ? vld4 : vld3;
        g_id  = (d == 0) ? id4  : id3;
        g_dat = (d == 0) ? dat4 : dat3;
        chk($sformatf("model_ready_d%0d", d), 32'(g_rdy), 32'(exp_rdy[d]));
        chk($sformatf("model_valid_d%0d", d), 32'(g_vld), 32'(m_valid[d]));
        if (m_valid[d]) begin
          chk($sformatf("model_id_d%0d", d), 32'(g_id), 32'(m_id[d]));
          chk($sformatf("model_data_d%0d", d), 32'(g_dat), 32'(m_data[d]));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rspr[d] = 1'b1;
      exp_rdy[d] = 4'b0000;
      for (int i = 0; i < 4; i++) begin
        opv[d][i] = 2'b00;
        av[d][i]  = 8'h0F;
        bv[d][i]  = 8'h00;
      end
    end
    rv[0] = 4'b1111;
    rv[1] = 4'b0111;

    // Reset values.
    tick();
    chk_en = 1'b1;
    mid();
    chk("rst_valid4", 32'(vld4), 0);
    chk("rst_id4", 32'(id4), 0);
    chk("rst_data4", 32'(dat4), 0);
    chk("rst_ready4", 32'(rdy4), 0);
    chk("rst_ready3", 32'(rdy3), 0);
    tick();
    rst = 1'b0;

    // All valid, NOT of 0x0F: round-robin order on both sizes.
    for (int k = 0; k < 7; k++) begin
      mid();
      chk($sformatf("rr_ready4_k%0d", k), 32'(rdy4), 32'(4'b0001 << (k % 4)));
      chk($sformatf("rr_ready3_k%0d", k), 32'(rdy3), 32'(3'b001 << (k % 3)));
      if (k > 0) begin
        chk($sformatf("rr_id4_k%0d", k), 32'(id4), 32'((k - 1) % 4));
        chk($sformatf("rr_id3_k%0d", k), 32'(id3), 32'((k - 1) % 3));
        chk($sformatf("rr_data4_k%0d", k), 32'(dat4), 32'h F0);
        chk($sformatf("rr_valid3_k%0d", k), 32'(vld3), 1);
      end
      tick();
    end

    // Single requester 2, AND.
    rv[1] = 4'b0000;
    rv[0] = 4'b0100;
    opv[0][2] = 2'b01; av[0][2] = 8'hCC; bv[0][2] = 8'hAA;
    mid();
    chk("and_ready4", 32'(rdy4), 32'h4);
    tick();
    rv[0] = 4'b1011;
    rspr[0] = 1'b0;
    opv[0][3] = 2'b10; av[0][3] = 8'hF0; bv[0][3] = 8'h3C;
    opv[0][0] = 2'b11; av[0][0] = 8'hF0; bv[0][0] = 8'h3C;

    // Stall: result held, nobody ready.
    for (int j = 0; j < 3; j++) begin
      if (j > 0) tick();
      mid();
      chk($sformatf("stall_ready_%0d", j), 32'(rdy4), 0);
      chk($sformatf("stall_id_%0d", j), 32'(id4), 2);
      chk($sformatf("stall_data_%0d", j), 32'(dat4), 32'h88);
    end
    tick();
    rspr[0] = 1'b1;
    mid();
    chk("resume_ready4", 32'(rdy4), 32'h8);
    tick();
    rv[0] = 4'b0011;
    mid();
    chk("or_data", 32'(dat4), 32'hFC);
    chk("or_id", 32'(id4), 3);
    chk("or_next_ready", 32'(rdy4), 32'h1);
    tick();
    mid();
    chk("xor_valid", 32'(vld4), 1);
    chk("xor_data", 32'(dat4), 32'hCC);
    tick();

    // Grant requester 1, then reset while its result is pending.
    rv[0] = 4'b0010;
    mid();
    chk("pre_rst_ready", 32'(rdy4), 32'h2);
    tick();
    rv[0] = 4'b1010;
    mid();
    chk("pre_rst_id", 32'(id4), 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", 32'(vld4), 0);
    chk("rst_mid_ready", 32'(rdy4), 0);
    tick();
    rst = 1'b0;
    mid();
    chk("post_rst_ready", 32'(rdy4), 32'h2);
    tick();

    // Randomized traffic, back-pressure and occasional resets.
    for (int c = 0; c < 2500; c++) begin
      rst = ($urandom_range(0, 149) == 0);
      for (int d = 0; d < 2; d++) begin
        rspr[d] = ($urandom_range(0, 3) != 0);
        for (int i = 0; i < nreq(d); i++) begin
          if (rv[d][i] && !exp_rdy[d][i]) begin
            if ($urandom_range(0, 7) == 0) rv[d][i] = 1'b0;
          end else begin
            rv[d][i]  = ($urandom_range(0, 2) != 0);
            opv[d][i] = 2'($urandom);
            av[d][i]  = 8'($urandom);
            bv[d][i]  = 8'($urandom);
          end
        end
      end
      tick();
    end
    rst = 1'b0;
    mid();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
